// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and redirect controller.
// Drives the backward-flowing stall/flush controls for the IF/ID and ID/EX
// pipeline registers. It handles three cases:
//   - load-use hazards,
//   - dependents of an in-flight mult/div (HI/LO busy tracking),
//   - squashes caused by a redirect resolved in EX.
// Optional feature macro: HAZARD_STATS_EN adds the StatsClr input and the
// StallCount/FlushCount saturating event counters.
module hazard_ctrl #(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       RsId,
  input  logic [4:0]       RtId,
  input  logic             UseRsId,
  input  logic             UseRtId,
  input  logic             HiLoReadId,
  input  logic             MulDivId,
  input  logic             MemReadEx,
  input  logic             RegWriteEx,
  input  logic [4:0]       RegDstEx,
  input  logic             MulDivStartEx,
  input  logic             RedirectEx,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             MulDivBusy
`ifdef HAZARD_STATS_EN
  ,
  input  logic             StatsClr,
  output logic [31:0]      StallCount,
  output logic [31:0]      FlushCount
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MD_BUSY = 1'b1
  } state_e;

  localparam int unsigned STAT_W = 32;
  localparam logic [CNT_W-1:0] MD_RELOAD = CNT_W'(MD_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic lu_hazard;
  logic md_hazard;

  assign MulDivBusy = (state_q == ST_MD_BUSY);

  // Hazard detection: a load into a non-zero register that ID reads, or an
  // HI/LO consumer (or another mult/div) while the unit is busy.
  always_comb begin
    lu_hazard = 1'b0;
    md_hazard = 1'b0;
    if (MemReadEx && RegWriteEx && (RegDstEx != 5'd0)) begin
      lu_hazard = (UseRsId && (RsId == RegDstEx)) ||
                  (UseRtId && (RtId == RegDstEx));
    end
    md_hazard = MulDivBusy && (HiLoReadId || MulDivId);
  end

  // Stall/flush outputs; a redirect squashes ID so any stall is dropped.
  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    IDEXFlush = 1'b0;
    if (RedirectEx) begin
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
    end else if (lu_hazard || md_hazard) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IDEXFlush = 1'b1;
    end
  end

  // Mult/div busy tracker next state; an issue while busy reloads the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (MulDivStartEx) begin
          state_d = ST_MD_BUSY;
          cnt_d   = MD_RELOAD;
        end
      end
      ST_MD_BUSY: begin
        if (MulDivStartEx) begin
          cnt_d = MD_RELOAD;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Busy tracker state register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [STAT_W-1:0] flush_cnt_q, flush_cnt_d;

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

  // Saturating event counters; clear wins over increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StatsClr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!PCWrite && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + STAT_W'(1);
      end
      if (IFIDFlush && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + STAT_W'(1);
      end
    end
  end

  // Event counter registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
`endif

endmodule
